// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: ALU opcodes
// that select it, FSM state encoding and flag bit positions. The ALU decode
// imports the same package so opcode values stay in one place.
package mdu_sequencer_pkg;

  // ALU opcodes routed to the multi-cycle unit
  localparam logic [4:0] ALU_MUL  = 5'd18;  // low word of unsigned product
  localparam logic [4:0] ALU_DIVU = 5'd19;  // unsigned quotient
  localparam logic [4:0] ALU_REMU = 5'd20;  // unsigned remainder

  // Bit positions inside the 4-bit {O,S,Z,C} flag vector
  localparam int FLAG_O = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // True for the opcodes this unit executes
  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative multiply / unsigned divide sequencer.
//
// Handshake: an op is taken on a rising clock edge when the unit is IDLE,
// start=1, kill=0 and alu_op is MUL/DIVU/REMU; stall is high combinationally
// in that cycle and through RUN so upstream holds. The result is announced by
// a one-cycle done pulse (state DONE); result/flags stay put until the next
// done. There is no queuing: start outside IDLE is ignored.
//
// Datapath registers:
//   acc - product accumulator (mul) / partial remainder (div)
//   x   - multiplicand shifting left (mul) / dividend shifting into quotient (div)
//   y   - multiplier shifting right (mul) / divisor (div)
// One WIDTH+1 adder/subtractor is shared between the two algorithms.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] s_1,
  input  logic [WIDTH-1:0] s_2,
  input  logic             kill,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  mdu_state_e       state;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] cnt;
  logic             div_zero;
  logic             rst_hold;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] x_nx;
  logic [WIDTH-1:0] y_nx;
  logic [WIDTH-1:0] fin_result;
  logic [3:0]       fin_flags;
  logic             unused_sum_bit;

  // The cycle right after reset never accepts, so stall stays low there even
  // with start held high through reset.
  assign accept = (state == ST_IDLE) && start && is_mdu_op(alu_op) && !kill && !rst_hold;
  assign stall  = accept || (state == ST_RUN);

  // Shared adder: add for mul, restoring trial subtract for div
  always_comb begin
    is_mul    = (op_q == ALU_MUL);
    shifted   = {acc, x[WIDTH-1]};
    add_a     = is_mul ? {1'b0, acc} : shifted;
    add_b     = is_mul ? {1'b0, x} : ~{1'b0, y};
    sum       = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, !is_mul};
    // Carry out of the subtract means shifted >= divisor
    no_borrow = sum[WIDTH+1];
  end

  // Bit WIDTH of the sum is never needed: the product keeps only its low word
  // and a successful restoring subtract always leaves a remainder < divisor.
  assign unused_sum_bit = sum[WIDTH];

  // Next datapath values for one iteration step
  always_comb begin
    acc_nx = acc;
    x_nx   = x;
    y_nx   = y;
    if (is_mul) begin
      if (y[0]) acc_nx = sum[WIDTH-1:0];
      x_nx = x << 1;
      y_nx = y >> 1;
    end else begin
      acc_nx = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
      x_nx   = {x[WIDTH-2:0], no_borrow};
    end
  end

  // Final result and flags, taken from the values after the last step
  always_comb begin
    fin_result = acc_nx;
    if (div_zero) begin
      fin_result = (op_q == ALU_DIVU) ? {WIDTH{1'b1}} : x;
    end else if (op_q == ALU_DIVU) begin
      fin_result = x_nx;
    end
    fin_flags         = 4'b0000;
    fin_flags[FLAG_O] = 1'b0;
    fin_flags[FLAG_S] = fin_result[WIDTH-1];
    fin_flags[FLAG_Z] = (fin_result == '0);
    fin_flags[FLAG_C] = 1'b0;
  end

  // Sequencer FSM with operand latch, iteration counter and registered outputs.
  // Divide-by-zero spends a single RUN cycle with no arithmetic so its result
  // appears one cycle after acceptance instead of WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      rst_hold <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      flags    <= 4'b0000;
    end else begin
      rst_hold <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= alu_op;
            acc   <= '0;
            x     <= s_1;
            y     <= s_2;
            state <= ST_RUN;
            if ((alu_op != ALU_MUL) && (s_2 == '0)) begin
              div_zero <= 1'b1;
              cnt      <= CNT_W'(1);
            end else begin
              div_zero <= 1'b0;
              cnt      <= CNT_W'(WIDTH);
            end
          end
        end
        ST_RUN: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            if (!div_zero) begin
              acc <= acc_nx;
              x   <= x_nx;
              y   <= y_nx;
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= fin_result;
              flags  <= fin_flags;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: reset values, mul/divu/remu results and
// flags, latency, divide-by-zero, kill and reset mid-op, start held high and
// back-to-back operations.
module tb_mdu_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] s_1;
  logic [WIDTH-1:0] s_2;
  logic             kill;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  int n_vec  = 0;
  int n_miss = 0;

  mdu_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .alu_op (alu_op),
    .s_1    (s_1),
    .s_2    (s_2),
    .kill   (kill),
    .stall  (stall),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count cycles from acceptance until done (first negedge after accept = 1)
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One op: accept, scramble inputs, wait for done, check latency/result/flags
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int cyc;
    @(negedge clk);
    alu_op = op;
    s_1    = a;
    s_2    = b;
    start  = 1'b1;
    #1 check({tag, "_stall_acc"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    start  = 1'b0;
    s_1    = $urandom;
    s_2    = $urandom_range(1, 1000);
    alu_op = 5'd18 + 5'($urandom_range(0, 2));
    wait_done(cyc);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
    check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int cyc;
    int n_done;

    rst    = 1'b1;
    start  = 1'b0;
    alu_op = 5'd0;
    s_1    = '0;
    s_2    = '0;
    kill   = 1'b0;
    repeat (3) @(negedge clk);

    // reset values, with a valid request held through reset
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    alu_op = 5'd18;
    s_1    = 32'd3;
    s_2    = 32'd3;
    start  = 1'b1;
    rst    = 1'b0;
    #1 check("post_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1 check("post_rst_no_accept", {31'd0, stall}, 32'd0);

    // unsupported opcode is ignored
    @(negedge clk);
    alu_op = 5'd7;
    start  = 1'b1;
    #1 check("badop_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("badop_stall2", {31'd0, stall}, 32'd0);
    check("badop_done", {31'd0, done}, 32'd0);
    start = 1'b0;

    // main function
    run_op("mul7x6", 5'd18, 32'd7, 32'd6, 33, 32'd42, 4'b0000);
    run_op("mulwrap", 5'd18, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 4'b0100);
    run_op("divu100_7", 5'd19, 32'd100, 32'd7, 33, 32'd14, 4'b0000);
    run_op("remu100_7", 5'd20, 32'd100, 32'd7, 33, 32'd2, 4'b0000);
    run_op("divu5_10", 5'd19, 32'd5, 32'd10, 33, 32'd0, 4'b0010);
    run_op("remu5_10", 5'd20, 32'd5, 32'd10, 33, 32'd5, 4'b0000);
    run_op("divu_big", 5'd19, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 4'b0100);
    run_op("divu123_0", 5'd19, 32'd123, 32'd0, 2, 32'hFFFF_FFFF, 4'b0100);
    run_op("remu123_0", 5'd20, 32'd123, 32'd0, 2, 32'd123, 4'b0000);

    // kill in RUN cycle 10: back to IDLE, no done, previous result kept
    @(negedge clk);
    alu_op = 5'd18;
    s_1    = 32'd3;
    s_2    = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_stall", {31'd0, stall}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("kill_no_done", n_done, 0);
    check("kill_result", result, 32'd123);
    check("kill_flags", {28'd0, flags}, 32'd0);

    // reset in the middle of RUN: outputs cleared, no done afterwards
    run_op("mul_pre", 5'd18, 32'd5, 32'd5, 33, 32'd25, 4'b0000);
    @(negedge clk);
    alu_op = 5'd18;
    s_1    = 32'd3;
    s_2    = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrun_result", result, 32'd0);
    check("rstrun_flags", {28'd0, flags}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rstrun_no_done", n_done, 0);

    // start held high: ignored in RUN/DONE, next op taken in the IDLE cycle after DONE
    @(negedge clk);
    alu_op = 5'd18;
    s_1    = 32'd9;
    s_2    = 32'd9;
    start  = 1'b1;
    @(negedge clk);
    s_1 = 32'd3;
    s_2 = 32'd4;
    wait_done(cyc);
    check("b2b_lat1", cyc, 33);
    check("b2b_res1", result, 32'd81);
    check("b2b_stall_done", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("b2b_idle_done", {31'd0, done}, 32'd0);
    check("b2b_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_lat2", cyc, 33);
    check("b2b_res2", result, 32'd12);
    check("b2b_flags2", {28'd0, flags}, 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
